receptor_32: RTL and testbench
==============================

RECEPTOR_32 -- requirements
Module: receptor_32

Interface
REQ-001 Parameter NB_DATA, default 32: width of the assembled output word.
REQ-002 Parameter NB_BYTE, default 8: data bits per UART frame.
REQ-003 Parameter N_TICKS, default 16: i_tick pulses per bit period (oversampling factor).
REQ-004 Parameter N_BYTES, default NB_DATA/NB_BYTE (4): number of frames per word.
REQ-005 i_clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_data  input  1  UART serial line; idle level high.
REQ-008 i_tick  input  1  single-cycle oversampling strobe from baudrate_gen.
REQ-009 o_data  output  NB_DATA  last complete received word, registered.
REQ-010 o_valid  output  1  single-cycle strobe: o_data holds a new word.
REQ-011 o_frame_error  output  1  single-cycle strobe: a stop bit was sampled low.

Function
REQ-012 Frame format SHALL be 1 start bit (low), NB_BYTE data bits LSB first, 1 stop bit (high), no parity.
REQ-013 Bit FSM states SHALL be IDLE, START, DATA, STOP; the tick counter and bit counter advance only on cycles with i_tick=1.
REQ-014 IDLE: on i_data=0, go to START with the tick counter cleared.
REQ-015 START: at the 8th tick (count N_TICKS/2-1), if i_data=0 go to DATA with counters cleared; if i_data=1, treat it as a glitch and return to IDLE with nothing recorded.
REQ-016 DATA: every N_TICKS ticks, sample i_data into the shift register MSB and shift right; after NB_BYTE samples go to STOP.
REQ-017 STOP: after N_TICKS ticks, sample i_data and return to IDLE.
REQ-018 Stop sampled high: the byte SHALL be stored in byte slot byte_cnt; byte 0 maps to o_data[7:0] (little-endian), and byte_cnt increments.
REQ-019 Stop sampled low: discard the byte and any partial word, clear byte_cnt to 0, and pulse o_frame_error for one cycle.
REQ-020 When the N_BYTES-th good byte is stored, o_data SHALL load the full word and o_valid SHALL pulse high for exactly one i_clk cycle, the cycle after the stop-sampling edge; byte_cnt wraps to 0.
REQ-021 o_data SHALL hold its value between o_valid pulses; partial words never appear on o_data.
REQ-022 The block SHALL accept back-to-back frames: a start edge seen in IDLE on the cycle after STOP completes SHALL be received normally.
REQ-023 The block has no backpressure: a consumer missing an o_valid pulse loses that word, and no buffering is provided.
REQ-024 o_valid and o_frame_error SHALL never be high in the same cycle.

Reset
REQ-025 While i_reset=1, the FSM SHALL be IDLE; tick counter, bit counter, byte_cnt, shift register, o_data, o_valid and o_frame_error SHALL all be 0.
REQ-026 Reset asserted mid-frame or mid-word SHALL abort reception with no o_valid pulse; reception restarts at byte 0 on the next start bit after release.
REQ-027 i_tick and i_data SHALL be ignored during reset.

Verification
REQ-028 Send word 0x99999999 as 4 frames of 0x99 -> exactly one o_valid pulse, with o_data=0x99999999 and o_frame_error never high.
REQ-029 Send bytes 0x05,0x07,0x03,0x01 back-to-back -> o_data=0x01030705 with one o_valid; then send 32 words 0x01030700|i for i=0..31 -> 32 pulses in order, with correct values.
REQ-030 Drive i_data low for 4 ticks, then high -> FSM returns to IDLE; a following word 0xDEADBEEF is received correctly.
REQ-031 Send 0x11, then 0x22 with its stop bit forced low -> o_frame_error pulses once and there is no o_valid; then bytes 0xAA,0xBB,0xCC,0xDD -> o_data=0xDDCCBBAA.
REQ-032 Assert i_reset for 2 cycles during the 3rd byte of a word -> all outputs read 0; the next full word 0x12345678 is received with a single o_valid.

Source files
------------

// File: rtl/receptor_32_if.sv
// receptor_32_if: serial line, tick strobe and assembled-word outputs of receptor_32
interface receptor_32_if #(parameter int NB_DATA = 32);
   logic               i_data;
   logic               i_tick;
   logic [NB_DATA-1:0] o_data;
   logic               o_valid;
   logic               o_frame_error;
   modport slave  (input i_data, i_tick, output o_data, o_valid, o_frame_error);
   modport master (output i_data, i_tick, input o_data, o_valid, o_frame_error);
endinterface

// File: rtl/receptor_32.sv
// receptor_32: oversampling UART receiver assembling N_BYTES frames into one little-endian word
module receptor_32 #(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = 8,
   parameter int N_TICKS = 16,
   parameter int N_BYTES = NB_DATA / NB_BYTE
) (
   input logic          i_clk,
   input logic          i_reset,
   receptor_32_if.slave bus
);
   localparam int TW = $clog2(N_TICKS);
   localparam int NW = $clog2(NB_BYTE);
   localparam int BW = N_BYTES > 1 ? $clog2(N_BYTES) : 1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t             state, state_n;
   logic [TW-1:0]      tick_cnt, tick_cnt_n;
   logic [NW-1:0]      bit_cnt, bit_cnt_n;
   logic [BW-1:0]      byte_cnt, byte_cnt_n;
   logic [NB_BYTE-1:0] sh, sh_n;
   logic [NB_DATA-1:0] word, word_n, data_n;
   logic               valid_n, ferr_n;

   // next state and datapath; counters only move on tick cycles, o_data only changes on a full word
   always_comb begin
      state_n    = state;
      tick_cnt_n = tick_cnt;
      bit_cnt_n  = bit_cnt;
      byte_cnt_n = byte_cnt;
      sh_n       = sh;
      word_n     = word;
      data_n     = bus.o_data;
      valid_n    = 1'b0;
      ferr_n     = 1'b0;
      case (state)
         IDLE: if (!bus.i_data) begin
            state_n    = START;
            tick_cnt_n = '0;
         end
         START: if (bus.i_tick) begin
            if (tick_cnt == TW'(N_TICKS / 2 - 1)) begin
               state_n    = bus.i_data ? IDLE : DATA;
               tick_cnt_n = '0;
               bit_cnt_n  = '0;
            end else tick_cnt_n = tick_cnt + 1'b1;
         end
         DATA: if (bus.i_tick) begin
            if (tick_cnt == TW'(N_TICKS - 1)) begin
               tick_cnt_n = '0;
               sh_n       = {bus.i_data, sh[NB_BYTE-1:1]};
               bit_cnt_n  = bit_cnt + 1'b1;
               state_n    = bit_cnt == NW'(NB_BYTE - 1) ? STOP : DATA;
            end else tick_cnt_n = tick_cnt + 1'b1;
         end
         STOP: if (bus.i_tick) begin
            if (tick_cnt == TW'(N_TICKS - 1)) begin
               state_n    = IDLE;
               tick_cnt_n = '0;
               if (bus.i_data) begin
                  word_n[byte_cnt*NB_BYTE +: NB_BYTE] = sh;
                  if (byte_cnt == BW'(N_BYTES - 1)) begin
                     data_n     = word_n;
                     valid_n    = 1'b1;
                     byte_cnt_n = '0;
                  end else byte_cnt_n = byte_cnt + 1'b1;
               end else begin
                  ferr_n     = 1'b1;
                  byte_cnt_n = '0;
               end
            end else tick_cnt_n = tick_cnt + 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   // state and output registers; reset overrides tick and serial inputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state             <= IDLE;
         tick_cnt          <= '0;
         bit_cnt           <= '0;
         byte_cnt          <= '0;
         sh                <= '0;
         word              <= '0;
         bus.o_data        <= '0;
         bus.o_valid       <= 1'b0;
         bus.o_frame_error <= 1'b0;
      end else begin
         state             <= state_n;
         tick_cnt          <= tick_cnt_n;
         bit_cnt           <= bit_cnt_n;
         byte_cnt          <= byte_cnt_n;
         sh                <= sh_n;
         word              <= word_n;
         bus.o_data        <= data_n;
         bus.o_valid       <= valid_n;
         bus.o_frame_error <= ferr_n;
      end
   end
endmodule

// File: tb/tb_receptor_32.sv
// tb_receptor_32: directed UART frames with a word scoreboard checked by an independent monitor
module tb_receptor_32;
   localparam int NT = 16;
   localparam int BIT_CLK = 2 * NT;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_q = 1'b1;
   int          n_chk = 0;
   int          n_fail = 0;
   int          ferr_cnt = 0;
   logic [31:0] expq[$];
   logic [31:0] last_w = '0;
   logic [31:0] exp_w;

   receptor_32_if #(.NB_DATA(32)) bus ();
   receptor_32 #(.NB_DATA(32), .NB_BYTE(8), .N_TICKS(NT), .N_BYTES(4)) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic bit_out(input logic b, input int clks);
      bus.i_data = b;
      repeat (clks) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic good_stop);
      bit_out(1'b0, BIT_CLK);
      for (int i = 0; i < 8; i++) bit_out(b[i], BIT_CLK);
      if (good_stop) bit_out(1'b1, BIT_CLK);
      else begin
         bit_out(1'b0, 24);
         bit_out(1'b1, 8);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      expq.push_back(w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
   endtask

   task automatic idle(input int bits);
      bit_out(1'b1, bits * BIT_CLK);
   endtask

   // tick strobe: one clock high, one clock low
   initial begin
      bus.i_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1 bus.i_tick = ~bus.i_tick;
      end
   end

   // remember whether reset was applied at the last edge
   always @(posedge clk) rst_q <= rst;

   // monitor: pop expected words on o_valid, otherwise o_data must hold
   always @(negedge clk) begin
      if (rst_q) last_w = '0;
      check("valid_ferr_excl", {31'b0, bus.o_valid & bus.o_frame_error}, 32'h0);
      if (bus.o_frame_error) ferr_cnt++;
      if (bus.o_valid) begin
         if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid: got o_data %h, expected no word", bus.o_data);
         end else begin
            exp_w = expq.pop_front();
            check("word", bus.o_data, exp_w);
            last_w = exp_w;
         end
      end else check("hold", bus.o_data, last_w);
   end

   initial begin
      bus.i_data = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_data", bus.o_data, 32'h0);
      check("rst_valid", {31'b0, bus.o_valid}, 32'h0);
      check("rst_ferr", {31'b0, bus.o_frame_error}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
      send_word(32'h99999999);
      idle(2);
      check("t1_ferr", ferr_cnt, 0);
      check("t1_pending", 32'(expq.size()), 32'h0);
      send_word(32'h01030705);
      for (int i = 0; i < 32; i++) send_word(32'h01030700 | i);
      idle(2);
      check("t2_pending", 32'(expq.size()), 32'h0);
      bit_out(1'b0, 8);
      idle(2);
      send_word(32'hDEADBEEF);
      idle(2);
      check("t3_pending", 32'(expq.size()), 32'h0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b0);
      idle(2);
      check("t4_ferr", ferr_cnt, 1);
      send_word(32'hDDCCBBAA);
      idle(2);
      send_byte(8'hAB, 1'b1);
      send_byte(8'hCD, 1'b1);
      bit_out(1'b0, BIT_CLK);
      bit_out(1'b1, BIT_CLK);
      bit_out(1'b0, BIT_CLK);
      rst = 1'b1;
      bus.i_data = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_data", bus.o_data, 32'h0);
      check("mid_rst_valid", {31'b0, bus.o_valid}, 32'h0);
      check("mid_rst_ferr", {31'b0, bus.o_frame_error}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
      send_word(32'h12345678);
      idle(2);
      check("final_pending", 32'(expq.size()), 32'h0);
      check("final_ferr", ferr_cnt, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
